mm_tile_engine: RTL and testbench

// - Parametrised tiled matrix-multiply engine: C[M][N] = A[M][K] x B[K][N], M=TILE*M_TILES, N=TILE*N_TILES.
// - Internal TILExTILE MAC array with true K-deep accumulation.
// - Operands fetched per k-step from external tile buffers over a fixed-latency read port.
// - Results streamed out one tile row per beat over valid/ready. Sits between the NPU operand buffers and the writeback path.

---
 rtl/mm_tile_engine_pkg.sv | 42 ++++
 rtl/mm_tile_engine_pe.sv | 39 +++
 rtl/mm_tile_engine.sv | 189 ++++++++++++++++++
 tb/tb_mm_tile_engine.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_tile_engine_pkg.sv
// Shared FSM state type, accumulator sizing and output saturation helper
// for the tiled matrix-multiply engine.
package npu_mm_pkg;

    typedef enum logic [2:0] {IDLE, FETCH, DRAIN, OUT, DONE} mm_state_e;

    typedef struct packed {
        logic [63:0] value;
        logic        clamped;
    } sat_res_t;

    function automatic int acc_width(input int data_w, input int k_depth);
        return 2 * data_w + $clog2(k_depth) + 1;
    endfunction

    // v is the accumulator already extended to 64 bits for the active signedness.
    function automatic sat_res_t saturate(input logic [63:0] v, input int out_w, input bit is_signed);
        sat_res_t r;
        longint   sv;
        longint   hi;
        longint   lo;
        sv = longint'(v);
        if (is_signed) begin
            hi = (longint'(1) <<< (out_w - 1)) - 1;
            lo = -(longint'(1) <<< (out_w - 1));
        end else begin
            hi = (longint'(1) <<< out_w) - 1;
            lo = 0;
        end
        r.clamped = 1'b1;
        if (sv > hi) begin
            r.value = 64'(hi);
        end else if (sv < lo) begin
            r.value = 64'(lo);
        end else begin
            r.value   = v;
            r.clamped = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/mm_tile_engine_pe.sv
// Single multiply-accumulate cell of the TILExTILE array.
module mm_pe #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 22,
    parameter int SIGNED = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              acc_en,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [ACC_W-1:0]  acc
);

    logic [ACC_W-1:0] a_ext;
    logic [ACC_W-1:0] b_ext;
    logic [ACC_W-1:0] prod;

    if (SIGNED != 0) begin : g_sext
        assign a_ext = {{(ACC_W - DATA_W){a[DATA_W-1]}}, a};
        assign b_ext = {{(ACC_W - DATA_W){b[DATA_W-1]}}, b};
    end else begin : g_zext
        assign a_ext = ACC_W'(a);
        assign b_ext = ACC_W'(b);
    end

    // Low ACC_W bits of the extended product are exact for both signednesses.
    assign prod = a_ext * b_ext;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            acc <= '0;
        end else if (acc_en) begin
            acc <= acc + prod;
        end
    end

endmodule

// File: rtl/mm_tile_engine.sv
// Tiled C = A x B engine: operand fetch FSM, TILExTILE MAC array, row-streamed results.
// Optional macro MATMUL_SAT_EN: clamp results to the OUT_W range and report it on sat_flag.
module mm_tile_engine
    import npu_mm_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int OUT_W   = 16,
    parameter int TILE    = 4,
    parameter int K_DEPTH = 32,
    parameter int M_TILES = 4,
    parameter int N_TILES = 4,
    parameter int SIGNED  = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic                        op_req,
    output logic [$clog2(K_DEPTH)-1:0]  op_k,
    output logic [$clog2(M_TILES)-1:0]  op_tm,
    output logic [$clog2(N_TILES)-1:0]  op_tn,
    input  logic [TILE*DATA_W-1:0]      op_a,
    input  logic [TILE*DATA_W-1:0]      op_b,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [TILE*OUT_W-1:0]       res_data,
    output logic [$clog2(TILE)-1:0]     res_row,
    output logic [$clog2(M_TILES)-1:0]  res_tm,
    output logic [$clog2(N_TILES)-1:0]  res_tn,
    output logic                        sat_flag
);

    localparam int ACC_W = acc_width(DATA_W, K_DEPTH);
    localparam int KW    = $clog2(K_DEPTH);
    localparam int MW    = $clog2(M_TILES);
    localparam int NW    = $clog2(N_TILES);
    localparam int RW    = $clog2(TILE);
    localparam logic [KW-1:0] K_LAST = KW'(K_DEPTH - 1);
    localparam logic [MW-1:0] M_LAST = MW'(M_TILES - 1);
    localparam logic [NW-1:0] N_LAST = NW'(N_TILES - 1);
    localparam logic [RW-1:0] R_LAST = RW'(TILE - 1);

    mm_state_e        state;
    logic [MW-1:0]    tm;
    logic [NW-1:0]    tn;
    logic             acc_en;
    logic             last_row;
    logic             last_tile;
    logic             enter_fetch;
    logic             row_sat;
    logic [ACC_W-1:0] acc [TILE][TILE];

    assign op_tm     = tm;
    assign op_tn     = tn;
    assign res_tm    = tm;
    assign res_tn    = tn;
    assign last_row  = (res_row == R_LAST);
    assign last_tile = (tm == M_LAST) && (tn == N_LAST);
    assign enter_fetch = (state == IDLE && start && !done) ||
                         (state == OUT && res_ready && last_row && !last_tile);

    for (genvar gi = 0; gi < TILE; gi++) begin : g_row
        for (genvar gj = 0; gj < TILE; gj++) begin : g_col
            mm_pe #(
                .DATA_W (DATA_W),
                .ACC_W  (ACC_W),
                .SIGNED (SIGNED)
            ) u_pe (
                .clk    (clk),
                .rst    (rst),
                .clear  (enter_fetch),
                .acc_en (acc_en),
                .a      (op_a[gi*DATA_W +: DATA_W]),
                .b      (op_b[gj*DATA_W +: DATA_W]),
                .acc    (acc[gi][gj])
            );
        end
    end

    always_comb begin
        logic [63:0] ext;
`ifdef MATMUL_SAT_EN
        sat_res_t    r;
        r = '0;
`endif
        ext      = '0;
        res_data = '0;
        row_sat  = 1'b0;
        for (int unsigned j = 0; j < TILE; j++) begin
            if (SIGNED != 0) begin
                ext = {{(64 - ACC_W){acc[res_row][j][ACC_W-1]}}, acc[res_row][j]};
            end else begin
                ext = 64'(acc[res_row][j]);
            end
`ifdef MATMUL_SAT_EN
            r = saturate(ext, OUT_W, SIGNED != 0);
            res_data[j*OUT_W +: OUT_W] = r.value[OUT_W-1:0];
            row_sat = row_sat | r.clamped;
`else
            res_data[j*OUT_W +: OUT_W] = ext[OUT_W-1:0];
`endif
        end
        if (!res_valid) begin
            res_data = '0;
            row_sat  = 1'b0;
        end
    end

    // done is registered out of DONE, so it is visible while already back in IDLE;
    // gating start with done keeps a start coincident with done from being taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            op_req    <= 1'b0;
            op_k      <= '0;
            tm        <= '0;
            tn        <= '0;
            acc_en    <= 1'b0;
            res_valid <= 1'b0;
            res_row   <= '0;
            sat_flag  <= 1'b0;
        end else begin
            done   <= 1'b0;
            acc_en <= op_req;
            case (state)
                IDLE: begin
                    if (start && !done) begin
                        state    <= FETCH;
                        busy     <= 1'b1;
                        sat_flag <= 1'b0;
                        tm       <= '0;
                        tn       <= '0;
                        op_k     <= '0;
                        op_req   <= 1'b1;
                    end
                end
                FETCH: begin
                    if (op_k == K_LAST) begin
                        op_req <= 1'b0;
                        op_k   <= '0;
                        state  <= DRAIN;
                    end else begin
                        op_k <= op_k + 1'b1;
                    end
                end
                DRAIN: begin
                    state     <= OUT;
                    res_valid <= 1'b1;
                    res_row   <= '0;
                end
                OUT: begin
                    if (res_ready) begin
                        sat_flag <= sat_flag | row_sat;
                        if (!last_row) begin
                            res_row <= res_row + 1'b1;
                        end else begin
                            res_valid <= 1'b0;
                            res_row   <= '0;
                            if (last_tile) begin
                                state <= DONE;
                            end else begin
                                state  <= FETCH;
                                op_req <= 1'b1;
                                if (tn == N_LAST) begin
                                    tn <= '0;
                                    tm <= tm + 1'b1;
                                end else begin
                                    tn <= tn + 1'b1;
                                end
                            end
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    tm    <= '0;
                    tn    <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mm_tile_engine.sv
// Self-checking bench for mm_tile_engine: unsigned and signed instances against a
// plain-arithmetic matrix model; honours MATMUL_SAT_EN.
module tb_mm_tile_engine;

    localparam int DATA_W  = 8;
    localparam int OUT_W   = 16;
    localparam int TILE    = 4;
    localparam int K_DEPTH = 32;
    localparam int M_TILES = 4;
    localparam int N_TILES = 4;
    localparam int M       = TILE * M_TILES;
    localparam int N       = TILE * N_TILES;
    localparam int ROWS    = M_TILES * N_TILES * TILE;
    localparam int JOB_CYC = 1 + M_TILES * N_TILES * (K_DEPTH + 1 + TILE);
    localparam int KW      = $clog2(K_DEPTH);
    localparam int MW      = $clog2(M_TILES);
    localparam int NW      = $clog2(N_TILES);
    localparam int RW      = $clog2(TILE);
    localparam int OUTS_W  = 3 + KW + MW + NW + 1 + TILE*OUT_W + RW + MW + NW + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start;
    logic res_ready;
    bit   sel;

    logic                   start_i [2];
    logic                   busy_i [2];
    logic                   done_i [2];
    logic                   op_req_i [2];
    logic [KW-1:0]          op_k_i [2];
    logic [MW-1:0]          op_tm_i [2];
    logic [NW-1:0]          op_tn_i [2];
    logic [TILE*DATA_W-1:0] op_a_i [2];
    logic [TILE*DATA_W-1:0] op_b_i [2];
    logic                   res_valid_i [2];
    logic [TILE*OUT_W-1:0]  res_data_i [2];
    logic [RW-1:0]          res_row_i [2];
    logic [MW-1:0]          res_tm_i [2];
    logic [NW-1:0]          res_tn_i [2];
    logic                   sat_i [2];

    mm_tile_engine #(.DATA_W(DATA_W), .OUT_W(OUT_W), .TILE(TILE), .K_DEPTH(K_DEPTH),
                     .M_TILES(M_TILES), .N_TILES(N_TILES), .SIGNED(0)) u_dut_u (
        .clk(clk), .rst(rst), .start(start_i[0]), .busy(busy_i[0]), .done(done_i[0]),
        .op_req(op_req_i[0]), .op_k(op_k_i[0]), .op_tm(op_tm_i[0]), .op_tn(op_tn_i[0]),
        .op_a(op_a_i[0]), .op_b(op_b_i[0]), .res_valid(res_valid_i[0]), .res_ready(res_ready),
        .res_data(res_data_i[0]), .res_row(res_row_i[0]), .res_tm(res_tm_i[0]),
        .res_tn(res_tn_i[0]), .sat_flag(sat_i[0]));

    mm_tile_engine #(.DATA_W(DATA_W), .OUT_W(OUT_W), .TILE(TILE), .K_DEPTH(K_DEPTH),
                     .M_TILES(M_TILES), .N_TILES(N_TILES), .SIGNED(1)) u_dut_s (
        .clk(clk), .rst(rst), .start(start_i[1]), .busy(busy_i[1]), .done(done_i[1]),
        .op_req(op_req_i[1]), .op_k(op_k_i[1]), .op_tm(op_tm_i[1]), .op_tn(op_tn_i[1]),
        .op_a(op_a_i[1]), .op_b(op_b_i[1]), .res_valid(res_valid_i[1]), .res_ready(res_ready),
        .res_data(res_data_i[1]), .res_row(res_row_i[1]), .res_tm(res_tm_i[1]),
        .res_tn(res_tn_i[1]), .sat_flag(sat_i[1]));

    assign start_i[0] = start && !sel;
    assign start_i[1] = start && sel;

    logic                  busy, done, op_req, res_valid, sat_flag;
    logic [TILE*OUT_W-1:0] res_data;
    logic [RW-1:0]         res_row;
    logic [MW-1:0]         res_tm;
    logic [NW-1:0]         res_tn;
    logic [OUTS_W-1:0]     outs;

    assign busy      = busy_i[sel];
    assign done      = done_i[sel];
    assign op_req    = op_req_i[sel];
    assign res_valid = res_valid_i[sel];
    assign res_data  = res_data_i[sel];
    assign res_row   = res_row_i[sel];
    assign res_tm    = res_tm_i[sel];
    assign res_tn    = res_tn_i[sel];
    assign sat_flag  = sat_i[sel];
    assign outs = {busy, done, op_req, op_k_i[sel], op_tm_i[sel], op_tn_i[sel], res_valid,
                   res_data, res_row, res_tm, res_tn, sat_flag};

    // Operand buffers: fixed one-cycle read latency, garbage when not requested.
    logic [DATA_W-1:0] a_mem [M][K_DEPTH];
    logic [DATA_W-1:0] b_mem [K_DEPTH][N];

    for (genvar u = 0; u < 2; u++) begin : g_mem
        always @(posedge clk) begin
            for (int i = 0; i < TILE; i++) begin
                if (op_req_i[u]) begin
                    op_a_i[u][i*DATA_W +: DATA_W] <= a_mem[op_tm_i[u]*TILE + i][op_k_i[u]];
                    op_b_i[u][i*DATA_W +: DATA_W] <= b_mem[op_k_i[u]][op_tn_i[u]*TILE + i];
                end else begin
                    op_a_i[u][i*DATA_W +: DATA_W] <= DATA_W'($urandom);
                    op_b_i[u][i*DATA_W +: DATA_W] <= DATA_W'($urandom);
                end
            end
        end
    end

    int passed = 0;
    int total  = 0;

    logic [TILE*OUT_W-1:0] got_d [$];
    logic [MW+NW+RW-1:0]   got_m [$];
    int                    done_cyc;
    int                    stall_bad;
    int                    nbad;
    int                    first_bad;
    logic [TILE*OUT_W-1:0] bad_got;
    logic [TILE*OUT_W-1:0] bad_want;
    logic                  end_sat;
    logic                  want_sat;

    // ---------------- reference model ----------------
    function automatic longint elem(input logic [DATA_W-1:0] x, input bit sgn);
        return sgn ? longint'($signed(x)) : longint'(x);
    endfunction

    function automatic longint dot(input int m, input int n, input bit sgn);
        longint s = 0;
        for (int k = 0; k < K_DEPTH; k++) s += elem(a_mem[m][k], sgn) * elem(b_mem[k][n], sgn);
        return s;
    endfunction

    function automatic logic [OUT_W-1:0] conv(input longint c, input bit sgn, output bit clamped);
`ifdef MATMUL_SAT_EN
        longint hi = sgn ? (longint'(1) <<< (OUT_W-1)) - 1 : (longint'(1) <<< OUT_W) - 1;
        longint lo = sgn ? -(longint'(1) <<< (OUT_W-1)) : 0;
`endif
        longint v = c;
        clamped = 1'b0;
`ifdef MATMUL_SAT_EN
        if (v > hi) begin v = hi; clamped = 1'b1; end
        else if (v < lo) begin v = lo; clamped = 1'b1; end
`endif
        return OUT_W'(v);
    endfunction

    function automatic logic [TILE*OUT_W-1:0] exp_row(input int r, input bit sgn, output bit clamped);
        logic [TILE*OUT_W-1:0] v;
        int t  = r / TILE;
        int m  = (t / N_TILES) * TILE + r % TILE;
        int n0 = (t % N_TILES) * TILE;
        bit c;
        clamped = 1'b0;
        for (int j = 0; j < TILE; j++) begin
            v[j*OUT_W +: OUT_W] = conv(dot(m, n0 + j, sgn), sgn, c);
            clamped |= c;
        end
        return v;
    endfunction

    function automatic logic [MW+NW+RW-1:0] exp_meta(input int r);
        int t = r / TILE;
        return {MW'(t / N_TILES), NW'(t % N_TILES), RW'(r % TILE)};
    endfunction

    // ---------------- stimulus ----------------
    task automatic fill_const(input logic [DATA_W-1:0] av, input logic [DATA_W-1:0] bv);
        for (int m = 0; m < M; m++) for (int k = 0; k < K_DEPTH; k++) a_mem[m][k] = av;
        for (int k = 0; k < K_DEPTH; k++) for (int n = 0; n < N; n++) b_mem[k][n] = bv;
    endtask

    task automatic fill_random();
        for (int m = 0; m < M; m++) for (int k = 0; k < K_DEPTH; k++) a_mem[m][k] = DATA_W'($urandom);
        for (int k = 0; k < K_DEPTH; k++) for (int n = 0; n < N; n++) b_mem[k][n] = DATA_W'($urandom);
    endtask

    task automatic fill_identity();
        for (int m = 0; m < M; m++) for (int k = 0; k < K_DEPTH; k++) a_mem[m][k] = (k == m) ? 1 : 0;
        for (int k = 0; k < K_DEPTH; k++) for (int n = 0; n < N; n++) b_mem[k][n] = DATA_W'(k + n);
    endtask

    // Runs one job on the selected instance, collecting accepted rows and the done latency.
    task automatic run_job(input int stall_at, input int stall_len, input bit poke);
        int                    stall_left = 0;
        bit                    stalled = 0;
        bit                    c;
        logic [TILE*OUT_W-1:0] e;
        logic [TILE*OUT_W-1:0] hold_d = '0;
        logic [RW-1:0]         hold_r = '0;
        got_d.delete();
        got_m.delete();
        done_cyc  = -1;
        stall_bad = 0;
        end_sat   = 1'bx;
        res_ready = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int cyc = 0; cyc < JOB_CYC + stall_len + 40; cyc++) begin
            if (done) begin
                done_cyc = cyc;
                end_sat  = sat_flag;
                break;
            end
            start = poke && (cyc % 41 == 7);
            if (!stalled && stall_len > 0 && res_valid && got_d.size() == stall_at) begin
                stalled = 1; stall_left = stall_len; hold_d = res_data; hold_r = res_row;
            end
            if (stall_left > 0) begin
                res_ready = 1'b0;
                if (res_data !== hold_d || res_row !== hold_r || res_valid !== 1'b1 || op_req !== 1'b0)
                    stall_bad++;
                stall_left--;
            end else begin
                res_ready = 1'b1;
                if (res_valid) begin
                    got_d.push_back(res_data);
                    got_m.push_back({res_tm, res_tn, res_row});
                end
            end
            @(posedge clk);
            #1;
        end
        start     = 1'b0;
        res_ready = 1'b1;
        nbad      = (got_d.size() > ROWS) ? got_d.size() - ROWS : 0;
        first_bad = -1;
        want_sat  = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            e = exp_row(r, sel, c);
            want_sat |= c;
            if (r >= got_d.size() || got_d[r] !== e || got_m[r] !== exp_meta(r)) begin
                nbad++;
                if (first_bad < 0) begin
                    first_bad = r;
                    bad_got   = (r < got_d.size()) ? got_d[r] : 'x;
                    bad_want  = e;
                end
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; start = 1'b0; res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = bit'(s);
            #0;
            total++;
            if (outs !== '0) $display("FAIL reset_outs[%0d] got %h want 0", s, outs);
            else passed++;
        end
        @(negedge clk) rst = 1'b0;
        sel = 0;
    endtask

    task automatic test_ones();
        logic [TILE*OUT_W-1:0] want = {TILE{16'd32}};
        fill_const(8'd1, 8'd1);
        sel = 0;
        run_job(-1, 0, 1'b0);
        total++;
        if (nbad !== 0) $display("FAIL ones_rows bad=%0d row%0d got %h want %h", nbad, first_bad, bad_got, bad_want);
        else passed++;
        total++;
        if (got_d.size() == 0 || got_d[0] !== want) $display("FAIL ones_lane got %h want %h", got_d.size() ? got_d[0] : 'x, want);
        else passed++;
        total++;
        if (done_cyc !== JOB_CYC) $display("FAIL ones_latency got %0d want %0d", done_cyc, JOB_CYC);
        else passed++;
        total++;
        if (end_sat !== want_sat) $display("FAIL ones_sat got %b want %b", end_sat, want_sat);
        else passed++;
    endtask

    task automatic test_max();
        logic [TILE*OUT_W-1:0] want;
`ifdef MATMUL_SAT_EN
        want = {TILE{16'hFFFF}};
`else
        want = {TILE{16'hC020}};
`endif
        fill_const(8'hFF, 8'hFF);
        sel = 0;
        run_job(-1, 0, 1'b0);
        total++;
        if (nbad !== 0) $display("FAIL max_rows bad=%0d row%0d got %h want %h", nbad, first_bad, bad_got, bad_want);
        else passed++;
        total++;
        if (got_d.size() == 0 || got_d[ROWS/2] !== want) $display("FAIL max_lane got %h want %h", got_d.size() ? got_d[ROWS/2] : 'x, want);
        else passed++;
        total++;
        if (end_sat !== want_sat) $display("FAIL max_sat got %b want %b", end_sat, want_sat);
        else passed++;
    endtask

    task automatic test_signed();
        logic [DATA_W-1:0]     av [2] = '{8'hFF, 8'h80};
        logic [DATA_W-1:0]     bv [2] = '{8'h02, 8'h80};
        logic [TILE*OUT_W-1:0] want [2];
        want[0] = {TILE{16'hFFC0}};
`ifdef MATMUL_SAT_EN
        want[1] = {TILE{16'h7FFF}};
`else
        want[1] = {TILE{16'h0000}};
`endif
        sel = 1;
        for (int p = 0; p < 2; p++) begin
            fill_const(av[p], bv[p]);
            run_job(-1, 0, 1'b0);
            total++;
            if (nbad !== 0) $display("FAIL signed%0d_rows bad=%0d row%0d got %h want %h", p, nbad, first_bad, bad_got, bad_want);
            else passed++;
            total++;
            if (got_d.size() == 0 || got_d[ROWS-1] !== want[p]) $display("FAIL signed%0d_lane got %h want %h", p, got_d.size() ? got_d[ROWS-1] : 'x, want[p]);
            else passed++;
            total++;
            if (end_sat !== want_sat) $display("FAIL signed%0d_sat got %b want %b", p, end_sat, want_sat);
            else passed++;
        end
        sel = 0;
    endtask

    task automatic test_identity();
        fill_identity();
        sel = 0;
        run_job(-1, 0, 1'b0);
        total++;
        if (nbad !== 0) $display("FAIL ident_rows bad=%0d row%0d got %h want %h", nbad, first_bad, bad_got, bad_want);
        else passed++;
        // tile (1,2) row 3 is C[7][8..11] = 15..18
        total++;
        if (got_d.size() < ROWS || got_d[27] !== {16'd18, 16'd17, 16'd16, 16'd15})
            $display("FAIL ident_map got %h want %h", got_d.size() >= ROWS ? got_d[27] : 'x, {16'd18, 16'd17, 16'd16, 16'd15});
        else passed++;
    endtask

    task automatic test_random();
        for (int s = 0; s < 2; s++) begin
            sel = bit'(s);
            fill_random();
            run_job(-1, 0, 1'b0);
            total++;
            if (nbad !== 0) $display("FAIL rand%0d_rows bad=%0d row%0d got %h want %h", s, nbad, first_bad, bad_got, bad_want);
            else passed++;
            total++;
            if (end_sat !== want_sat) $display("FAIL rand%0d_sat got %b want %b", s, end_sat, want_sat);
            else passed++;
        end
        sel = 0;
    endtask

    task automatic test_stall();
        int at = $urandom_range(1, ROWS - 1);
        fill_random();
        sel = 0;
        run_job(at, 10, 1'b0);
        total++;
        if (stall_bad !== 0) $display("FAIL stall_hold got %0d unstable cycles want 0", stall_bad);
        else passed++;
        total++;
        if (done_cyc !== JOB_CYC + 10) $display("FAIL stall_latency got %0d want %0d", done_cyc, JOB_CYC + 10);
        else passed++;
        total++;
        if (nbad !== 0) $display("FAIL stall_rows bad=%0d row%0d got %h want %h", nbad, first_bad, bad_got, bad_want);
        else passed++;
    endtask

    // Called right after a job returns, i.e. in the cycle done is high.
    task automatic test_start_at_done();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        total++;
        if (busy !== 1'b0 || op_req !== 1'b0) $display("FAIL start_at_done busy=%b op_req=%b want 0 0", busy, op_req);
        else passed++;
    endtask

    task automatic test_mid_reset();
        fill_const(8'd1, 8'd1);
        sel = 0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        total++;
        if (op_req !== 1'b1 || busy !== 1'b1) $display("FAIL midrst_fetch op_req=%b busy=%b want 1 1", op_req, busy);
        else passed++;
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (outs !== '0) $display("FAIL midrst_outs got %h want 0", outs);
        else passed++;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        total++;
        if (outs !== '0) $display("FAIL midrst_idle got %h want 0", outs);
        else passed++;
        run_job(-1, 0, 1'b1);
        total++;
        if (nbad !== 0) $display("FAIL midrst_rows bad=%0d row%0d got %h want %h", nbad, first_bad, bad_got, bad_want);
        else passed++;
        total++;
        if (done_cyc !== JOB_CYC) $display("FAIL midrst_latency got %0d want %0d", done_cyc, JOB_CYC);
        else passed++;
    endtask

    initial begin
        sel = 0;
        test_reset();
        test_ones();
        test_max();
        test_signed();
        test_identity();
        test_random();
        test_stall();
        test_start_at_done();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog timeout passed=%0d total=%0d", passed, total);
        $fatal(1);
    end

endmodule
